// File: rtl/light_pattern_pkg.sv
// Shared types for the LED pattern generator: requested modes, FSM states and bounce direction.
package light_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CALM    = 2'b00,
    MODE_SWEEP_R = 2'b01,
    MODE_SWEEP_L = 2'b10,
    MODE_BOUNCE  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CALM_A,
    CALM_B,
    SWEEP,
    BOUNCE
  } state_e;

  typedef enum logic {
    UP,
    DN
  } dir_e;

endpackage

// File: rtl/light_pattern_if.sv
// Switch-side controls and lamp-side outputs of the pattern generator.
// LIGHT_PATTERN_WRAP_CNT_EN adds the wrap_count signal.
interface light_pattern_if #(
  parameter int NUM_LEDS = 5
);
  import light_pattern_pkg::*;

  mode_e               mode;
  logic                hold;
  logic                step_tick;
  logic [NUM_LEDS-1:0] leds;
`ifdef LIGHT_PATTERN_WRAP_CNT_EN
  logic [7:0]          wrap_count;

  modport master (output mode, hold, input step_tick, leds, wrap_count);
  modport slave  (input mode, hold, output step_tick, leds, wrap_count);
`else
  modport master (output mode, hold, input step_tick, leds);
  modport slave  (input mode, hold, output step_tick, leds);
`endif

endinterface

// File: rtl/light_pattern_gen_prescaler.sv
// Free-running step prescaler: strobes once every TICK_COUNT cycles, frozen while hold is high.
module tick_prescaler #(
  parameter int TICK_COUNT = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hold,
  output logic step_tick
);

  localparam int               CNT_W    = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // hold masks a coincident terminal count, so the step lands on the first free cycle
  assign step_tick = (cnt_q == CNT_LAST) && !hold;

endmodule

// File: rtl/light_pattern_gen.sv
// LED pattern FSM (calm / sweep right / sweep left / bounce) stepped by an internal prescaler.
// Define LIGHT_PATTERN_WRAP_CNT_EN to add the saturating pattern-period counter wrap_count.
module light_pattern_gen
  import light_pattern_pkg::*;
#(
  parameter int NUM_LEDS   = 5,
  parameter int TICK_COUNT = 25_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  light_pattern_if.slave  bus
);

  localparam int                  POS_W   = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0]    POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] ONE     = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] CENTER  = (NUM_LEDS % 2 == 1)
                                          ? (ONE << (NUM_LEDS / 2))
                                          : ({{(NUM_LEDS-2){1'b0}}, 2'b11} << (NUM_LEDS / 2 - 1));
  localparam logic [NUM_LEDS-1:0] EDGES   = {1'b1, {(NUM_LEDS-2){1'b0}}, 1'b1};

  function automatic logic [NUM_LEDS-1:0] one_hot(input logic [POS_W-1:0] p);
    return ONE << p;
  endfunction

  logic                step_tick;
  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  tick_prescaler #(
    .TICK_COUNT (TICK_COUNT)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold      (bus.hold),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CALM_A;
      mode_q  <= MODE_CALM;
      dir_q   <= UP;
      pos_q   <= '0;
      leds_q  <= CENTER;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    leds_d  = leds_q;
    if (step_tick) begin
      if (bus.mode != mode_q) begin
        // A new mode only loads its start pattern; advancing resumes on the following step
        mode_d = bus.mode;
        dir_d  = UP;
        unique case (bus.mode)
          MODE_CALM:    begin state_d = CALM_A; pos_d = '0;      end
          MODE_SWEEP_R: begin state_d = SWEEP;  pos_d = POS_MAX; end
          MODE_SWEEP_L: begin state_d = SWEEP;  pos_d = '0;      end
          default:      begin state_d = BOUNCE; pos_d = '0;      end
        endcase
      end else begin
        unique case (state_q)
          CALM_A: state_d = CALM_B;
          CALM_B: state_d = CALM_A;
          SWEEP: begin
            if (mode_q == MODE_SWEEP_R) pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
            else                        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
          end
          default: begin
            // Turn around on the end lamp itself so it is never lit on two consecutive steps
            if (dir_q == UP) begin
              if (pos_q == POS_MAX) begin dir_d = DN; pos_d = POS_MAX - POS_W'(1); end
              else                        pos_d = pos_q + POS_W'(1);
            end else begin
              if (pos_q == '0) begin dir_d = UP; pos_d = POS_W'(1); end
              else                   pos_d = pos_q - POS_W'(1);
            end
          end
        endcase
      end
      leds_d = (state_d == CALM_A) ? CENTER :
               (state_d == CALM_B) ? EDGES  : one_hot(pos_d);
    end
  end

  assign bus.step_tick = step_tick;
  assign bus.leds      = leds_q;

`ifdef LIGHT_PATTERN_WRAP_CNT_EN
  logic       mode_chg;
  logic       wrap_evt;
  logic [7:0] wrap_q;

  always_comb begin
    mode_chg = step_tick && (bus.mode != mode_q);
    wrap_evt = 1'b0;
    if (step_tick && !mode_chg) begin
      unique case (state_q)
        CALM_A:  wrap_evt = 1'b0;
        CALM_B:  wrap_evt = 1'b1;
        SWEEP:   wrap_evt = (mode_q == MODE_SWEEP_R) ? (pos_q == '0) : (pos_q == POS_MAX);
        default: wrap_evt = (dir_q == DN) && (pos_q == POS_W'(1));
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= '0;
    end else if (mode_chg) begin
      wrap_q <= '0;
    end else if (wrap_evt && (wrap_q != 8'hFF)) begin
      wrap_q <= wrap_q + 8'd1;
    end
  end

  assign bus.wrap_count = wrap_q;
`endif

endmodule
